czono_unplus: RTL
=================

# czono_unplus

Sequential inverse of the constrained-zonotope Minkowski sum. Given a sum S = Z ⊕ W and the known addend Z, it recovers W:
- center: W.c = S.c − Z.c
- generators: the trailing S.G columns
- constraints: the lower-right S.A block and the trailing S.b rows

It sits downstream of the sum block in the CZonotope datapath, for example to peel off a disturbance set. Results are registered, and the block reports completion with a done pulse.

## Interface
Parameters:
- NMAX, 512, max state dimension n
- NGMAX, 512, max generators ng
- NCMAX, 512, max constraints nc
- DATA_WIDTH, 32, element width (Add_Sub operand width)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- start_i  in  1  start request; sampled only in IDLE
- S  CZonotope  —  sum operand; must be held stable from start_i until done_o
- Z  CZonotope  —  known addend; must be held stable from start_i until done_o
- W  CZonotope  —  recovered set; all fields registered
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse in DONE
- err_o  out  1  dimension error; sticky until next start
- mismatch_o  out  1  consistency failure (see Configuration); sticky until next start

## Operation
FSM states: IDLE, CHECK, SUB, CONS, DONE.
- **IDLE:** when start_i=1, go to CHECK and clear err_o and mismatch_o. start_i is ignored in every other state.
- **CHECK:** the error condition is S.n≠Z.n, or S.n=0, or S.ng<Z.ng, or S.nc<Z.nc.
  - On error: set err_o=1, W.n/ng/nc=0, go to DONE.
  - Otherwise: W.n=S.n, W.ng=S.ng−Z.ng, W.nc=S.nc−Z.nc, row counter r=0, go to SUB.
- **SUB:** one state row per cycle.
  - W.c[r] = Add_Sub(a=S.c[r], b=Z.c[r], AddBar_Sub=1).
  - W.G[r][j] = S.G[r][j+Z.ng] for j<W.ng; 0 for all other j.
  - At r=W.n−1: if W.nc=0 go to DONE, else set k=0 and go to CONS.
- **CONS:** one constraint row per cycle.
  - W.A[k][j] = S.A[k+Z.nc][j+Z.ng] for j<W.ng; 0 for all other j.
  - W.b[k] = S.b[k+Z.nc].
  - At k=W.nc−1 go to DONE.
- **DONE:** assert done_o for one cycle, then go to IDLE. W holds its value until the next successful CHECK overwrites the dimensions.
- **Stale entries:** rows ≥W.n and constraint rows ≥W.nc are not rewritten. CHECK clears them, meaning all of W.c, W.G, W.A and W.b are zeroed in the cycle CHECK passes.
- **Arithmetic:** Add_Sub semantics apply (DATA_WIDTH result, with overflow behaviour set by Add_Sub). Index arithmetic is unsigned, with widths $clog2(NMAX), $clog2(NGMAX) and $clog2(NCMAX) plus one bit.

## Timing
- Reset: state=IDLE, counters=0, busy_o=0, done_o=0, err_o=0, mismatch_o=0, and every W field is 0.
- Latency from the start_i cycle to the done_o cycle: 2 + W.n + W.nc cycles.
- An error path takes exactly 2 cycles to done_o.
- Start back-to-back: start_i asserted in the cycle after DONE (state IDLE) is accepted.
- start_i held high continuously: the block restarts after each DONE.
- rst_i mid-operation: return to IDLE within that clock and restore all reset values; no done_o is produced.
- Valid-data window: W fields are valid from the cycle done_o is high until the next accepted start.

## Configuration
- Macro: CZ_UNPLUS_CHECK_EN.
- Defined: the block verifies that S actually contains Z.
  - In SUB: S.G[r][j] must equal Z.G[r][j] for j<Z.ng.
  - In CONS: S.A[k+Z.nc][j] must be 0 for j<Z.ng.
  - Over the first Z.nc constraint rows: S.A and S.b must match Z. An extra cycle per row is allowed here, adding Z.nc cycles of latency in a PREFIX sub-phase before CONS.
  - Any mismatch sets mismatch_o=1. Results are still produced.
- Undefined: mismatch_o is tied to 0, no compare logic is built, and latency is exactly 2+W.n+W.nc.

## Test plan
- **Basic:** Z.n=2, c=[1,2], ng=1, nc=0; S.n=2, c=[5,9], ng=3, G row0=[7,3,4]; start → done_o at cycle 4, W.c=[4,7], W.ng=2, W.G row0=[3,4], err_o=0.
- **Constraints:** Z.ng=1, Z.nc=1; S.ng=2, S.nc=3, S.A rows1..2 col1=[6,8], S.b=[x,10,11] → W.nc=2, W.A col0=[6,8], W.b=[10,11], latency 2+n+2.
- **Error:** S.n=3, Z.n=2 → err_o=1, W.n=0, done_o exactly 2 cycles after start. Repeat with S.ng=1, Z.ng=2 → same result.
- **Reset mid-SUB:** assert rst_i in the 2nd SUB cycle → next cycle busy_o=0, W all zero, no done_o; a following start completes normally.
- **Ignored start and back-to-back:** pulse start_i while busy → no effect; start in the cycle after DONE → second done_o after a full latency.
- **CZ_UNPLUS_CHECK_EN:** S.G[0][0]≠Z.G[0][0] → mismatch_o=1 at done_o with W still correct. With the macro undefined → mismatch_o=0.

Source files
------------

// File: rtl/czono_unplus.sv
// czono_unplus: sequential inverse of the constrained-zonotope Minkowski sum, recovering W from S = Z (+) W
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : start request, sampled only in IDLE
//   s_*_i, z_*_i   : sum S and known addend Z (n, ng, nc, c, G, A, b), stable while busy
//   w_*_o          : registered recovered set W
//   busy_o, done_o : not-IDLE flag, one-cycle completion pulse
//   err_o          : dimension error, sticky until next start
//   mismatch_o     : S-does-not-contain-Z flag, built only with CZ_UNPLUS_CHECK_EN defined
module czono_unplus #(
  parameter int NMAX = 512,
  parameter int NGMAX = 512,
  parameter int NCMAX = 512,
  parameter int DATA_WIDTH = 32,
  localparam int NW = $clog2(NMAX) + 1,
  localparam int GW = $clog2(NGMAX) + 1,
  localparam int CW = $clog2(NCMAX) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [NW-1:0]         s_n_i,
  input  logic [GW-1:0]         s_ng_i,
  input  logic [CW-1:0]         s_nc_i,
  input  logic [DATA_WIDTH-1:0] s_c_i [NMAX],
  input  logic [DATA_WIDTH-1:0] s_g_i [NMAX][NGMAX],
  input  logic [DATA_WIDTH-1:0] s_a_i [NCMAX][NGMAX],
  input  logic [DATA_WIDTH-1:0] s_b_i [NCMAX],
  input  logic [NW-1:0]         z_n_i,
  input  logic [GW-1:0]         z_ng_i,
  input  logic [CW-1:0]         z_nc_i,
  input  logic [DATA_WIDTH-1:0] z_c_i [NMAX],
  input  logic [DATA_WIDTH-1:0] z_g_i [NMAX][NGMAX],
  input  logic [DATA_WIDTH-1:0] z_a_i [NCMAX][NGMAX],
  input  logic [DATA_WIDTH-1:0] z_b_i [NCMAX],
  output logic [NW-1:0]         w_n_o,
  output logic [GW-1:0]         w_ng_o,
  output logic [CW-1:0]         w_nc_o,
  output logic [DATA_WIDTH-1:0] w_c_o [NMAX],
  output logic [DATA_WIDTH-1:0] w_g_o [NMAX][NGMAX],
  output logic [DATA_WIDTH-1:0] w_a_o [NCMAX][NGMAX],
  output logic [DATA_WIDTH-1:0] w_b_o [NCMAX],
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  mismatch_o
);
  localparam int NI = $clog2(NMAX);
  localparam int GI = $clog2(NGMAX);
  localparam int CI = $clog2(NCMAX);
  typedef enum logic [2:0] {
    IDLE, CHECK, SUB, CONS, DONE
`ifdef CZ_UNPLUS_CHECK_EN
    , PREFIX
`endif
  } state_t;
  state_t state_q, state_d;
  logic [NW-1:0] r_q, r_d, w_n_q, w_n_d;
  logic [CW-1:0] k_q, k_d, w_nc_q, w_nc_d;
  logic [GW-1:0] w_ng_q, w_ng_d;
  logic err_q, err_d;
  logic [DATA_WIDTH-1:0] w_c_q [NMAX], w_c_d [NMAX];
  logic [DATA_WIDTH-1:0] w_g_q [NMAX][NGMAX], w_g_d [NMAX][NGMAX];
  logic [DATA_WIDTH-1:0] w_a_q [NCMAX][NGMAX], w_a_d [NCMAX][NGMAX];
  logic [DATA_WIDTH-1:0] w_b_q [NCMAX], w_b_d [NCMAX];
  logic [NI-1:0] ri;
  logic [CI-1:0] ki, ks;
  assign ri = r_q[NI-1:0];
  assign ki = k_q[CI-1:0];
  // source constraint row in S sits below Z's nc rows
  assign ks = CI'(k_q + z_nc_i);
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    k_d = k_q;
    err_d = err_q;
    w_n_d = w_n_q;
    w_ng_d = w_ng_q;
    w_nc_d = w_nc_q;
    w_c_d = w_c_q;
    w_g_d = w_g_q;
    w_a_d = w_a_q;
    w_b_d = w_b_q;
    case (state_q)
      IDLE: begin
        state_d = start_i ? CHECK : IDLE;
        err_d = start_i ? 1'b0 : err_q;
      end
      CHECK: begin
        if (s_n_i != z_n_i || s_n_i == '0 || s_ng_i < z_ng_i || s_nc_i < z_nc_i) begin
          err_d = 1'b1;
          w_n_d = '0;
          w_ng_d = '0;
          w_nc_d = '0;
          state_d = DONE;
        end else begin
          w_n_d = s_n_i;
          w_ng_d = s_ng_i - z_ng_i;
          w_nc_d = s_nc_i - z_nc_i;
          r_d = '0;
          k_d = '0;
          w_c_d = '{default: '0};
          w_g_d = '{default: '0};
          w_a_d = '{default: '0};
          w_b_d = '{default: '0};
          state_d = SUB;
        end
      end
      SUB: begin
        w_c_d[ri] = s_c_i[ri] - z_c_i[ri];
        for (int j = 0; j < NGMAX; j++)
          w_g_d[ri][j] = (GW'(j) < w_ng_q) ? s_g_i[ri][GI'(GW'(j) + z_ng_i)] : '0;
        r_d = r_q + NW'(1);
`ifdef CZ_UNPLUS_CHECK_EN
        if (r_q == w_n_q - NW'(1))
          state_d = (z_nc_i != '0) ? PREFIX : (w_nc_q == '0) ? DONE : CONS;
`else
        if (r_q == w_n_q - NW'(1))
          state_d = (w_nc_q == '0) ? DONE : CONS;
`endif
      end
      CONS: begin
        for (int j = 0; j < NGMAX; j++)
          w_a_d[ki][j] = (GW'(j) < w_ng_q) ? s_a_i[ks][GI'(GW'(j) + z_ng_i)] : '0;
        w_b_d[ki] = s_b_i[ks];
        k_d = k_q + CW'(1);
        state_d = (k_q == w_nc_q - CW'(1)) ? DONE : CONS;
      end
`ifdef CZ_UNPLUS_CHECK_EN
      PREFIX: begin
        k_d = (k_q == z_nc_i - CW'(1)) ? '0 : k_q + CW'(1);
        state_d = (k_q != z_nc_i - CW'(1)) ? PREFIX : (w_nc_q == '0) ? DONE : CONS;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      r_q <= '0;
      k_q <= '0;
      err_q <= 1'b0;
      w_n_q <= '0;
      w_ng_q <= '0;
      w_nc_q <= '0;
      w_c_q <= '{default: '0};
      w_g_q <= '{default: '0};
      w_a_q <= '{default: '0};
      w_b_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      k_q <= k_d;
      err_q <= err_d;
      w_n_q <= w_n_d;
      w_ng_q <= w_ng_d;
      w_nc_q <= w_nc_d;
      w_c_q <= w_c_d;
      w_g_q <= w_g_d;
      w_a_q <= w_a_d;
      w_b_q <= w_b_d;
    end
  end
`ifdef CZ_UNPLUS_CHECK_EN
  logic mis_q, mis_d;
  // SUB: leading G columns must be Z.G; CONS: coupling block must be 0; PREFIX: leading A/b rows must be Z's
  always_comb begin
    mis_d = mis_q;
    for (int j = 0; j < NGMAX; j++) begin
      mis_d |= state_q == SUB && GW'(j) < z_ng_i && s_g_i[ri][j] != z_g_i[ri][j];
      mis_d |= state_q == CONS && GW'(j) < z_ng_i && s_a_i[ks][j] != '0;
      mis_d |= state_q == PREFIX && GW'(j) < s_ng_i &&
               s_a_i[ki][j] != ((GW'(j) < z_ng_i) ? z_a_i[ki][j] : '0);
    end
    mis_d |= state_q == PREFIX && s_b_i[ki] != z_b_i[ki];
    mis_d = (state_q == IDLE && start_i) ? 1'b0 : mis_d;
  end
  always_ff @(posedge clk_i) mis_q <= rst_i ? 1'b0 : mis_d;
  assign mismatch_o = mis_q;
`else
  logic unused_z;
  always_comb begin
    unused_z = 1'b0;
    for (int i = 0; i < NMAX; i++)
      for (int j = 0; j < NGMAX; j++)
        unused_z ^= ^z_g_i[i][j];
    for (int i = 0; i < NCMAX; i++) begin
      unused_z ^= ^z_b_i[i];
      for (int j = 0; j < NGMAX; j++)
        unused_z ^= ^z_a_i[i][j];
    end
  end
  assign mismatch_o = 1'b0;
`endif
  assign w_n_o = w_n_q;
  assign w_ng_o = w_ng_q;
  assign w_nc_o = w_nc_q;
  assign w_c_o = w_c_q;
  assign w_g_o = w_g_q;
  assign w_a_o = w_a_q;
  assign w_b_o = w_b_q;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign err_o = err_q;
endmodule
